// File: rtl/router_fsm_ctrl_n.sv
// Input controller for a 1xNUM_CH packet router: header decode, payload/parity sequencing, full recovery.
// Optional macro WAIT_TIMEOUT_EN adds a bounded wait for the destination FIFO to drain.
module router_fsm_ctrl_n #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] din,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [ADDR_W-1:0] dest_sel,
  output logic              drop_pkt
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_e;

  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("router_fsm_ctrl_n: NUM_CH out of range");
  end
  if ((1 << ADDR_W) < NUM_CH) begin : g_bad_addr_w
    $error("router_fsm_ctrl_n: ADDR_W too narrow for NUM_CH");
  end
  if (WAIT_TIMEOUT < 1) begin : g_bad_timeout
    $error("router_fsm_ctrl_n: WAIT_TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] dest_sel_q, dest_sel_d;
  logic              drop_pkt_q, drop_pkt_d;

  // One-hot channel matches keep every per-channel lookup in range even for illegal addresses.
  logic [NUM_CH-1:0] din_hit;
  logic [NUM_CH-1:0] dest_hit;
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
    assign din_hit[gi]  = (din == ADDR_W'(gi));
    assign dest_hit[gi] = (dest_sel_q == ADDR_W'(gi));
  end

  logic din_valid;
  logic din_empty;
  logic dest_empty;
  logic dest_srst;
  assign din_valid  = ({1'b0, din} < NUM_CH_L);
  assign din_empty  = |(fifo_empty & din_hit);
  assign dest_empty = |(fifo_empty & dest_hit);
  assign dest_srst  = |(soft_rst & dest_hit);

  logic wait_expired;

`ifdef WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Held at zero outside the wait state, so every entry starts a fresh count.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == WAIT_TILL_EMPTY) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign wait_expired = (wait_cnt_q == CNT_LAST);
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dest_sel_d = dest_sel_q;
    drop_pkt_d = 1'b0;
    if (state_q != DECODE_ADDRESS && dest_srst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (din_valid) begin
              dest_sel_d = din;
              state_d    = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end else begin
              state_d    = DROP_PACKET;
              drop_pkt_d = 1'b1;
            end
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full) begin
            state_d = FIFO_FULL_STATE;
          end else if (!pkt_valid) begin
            state_d = LOAD_PARITY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (dest_empty) begin
            state_d = LOAD_FIRST_DATA;
          end else if (wait_expired) begin
            state_d    = DROP_PACKET;
            drop_pkt_d = 1'b1;
          end
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) begin
            state_d = LOAD_AFTER_FULL;
          end
        end
        LOAD_AFTER_FULL: begin
          if (parity_done) begin
            state_d = DECODE_ADDRESS;
          end else if (low_pkt_valid) begin
            state_d = LOAD_PARITY;
          end else begin
            state_d = LOAD_DATA;
          end
        end
        LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        // Parity byte of a dropped packet is swallowed on the first idle cycle.
        DROP_PACKET: begin
          if (!pkt_valid) begin
            state_d = DECODE_ADDRESS;
          end
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DECODE_ADDRESS;
      dest_sel_q <= '0;
      drop_pkt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_sel_q <= dest_sel_d;
      drop_pkt_q <= drop_pkt_d;
    end
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = ld_state | laf_state | (state_q == LOAD_PARITY);
  assign busy          = !(detect_add | ld_state | (state_q == DROP_PACKET));
  assign dest_sel      = dest_sel_q;
  assign drop_pkt      = drop_pkt_q;

endmodule

// File: tb/tb_router_fsm_ctrl_n.sv
// Bench for router_fsm_ctrl_n: phase-level model checked every cycle plus literal phase traces per scenario.
module tb_router_fsm_ctrl_n;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;
  localparam int WT     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] din = 2'd0;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_rst = 3'b000;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy, drop_pkt;
  logic [1:0] dest_sel;

  router_fsm_ctrl_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_rst(soft_rst), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .write_enb_reg(write_enb_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy),
    .dest_sel(dest_sel), .drop_pkt(drop_pkt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
    end
  endtask

  // Phase-level model: packet phases by name, wait measured in elapsed cycles.
  string ph = "DA";
  string nxt;
  int    m_dest = 0;
  bit    m_drop = 1'b0;
  int    m_wait = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = "DA"; m_dest = 0; m_drop = 1'b0; m_wait = 0;
    end else begin
      nxt = ph;
      if (ph != "DA" && soft_rst[m_dest]) nxt = "DA";
      else if (ph == "DA") begin
        if (pkt_valid) begin
          if (int'(din) < NUM_CH) begin
            m_dest = int'(din);
            if (fifo_empty[din]) nxt = "LFD"; else nxt = "WTE";
          end else nxt = "DROP";
        end
      end
      else if (ph == "LFD") nxt = "LD";
      else if (ph == "LD") begin
        if (fifo_full) nxt = "FFS"; else if (!pkt_valid) nxt = "LP";
      end
      else if (ph == "WTE") begin
        m_wait++;
        if (fifo_empty[m_dest]) nxt = "LFD";
`ifdef WAIT_TIMEOUT_EN
        else if (m_wait >= WT) nxt = "DROP";
`endif
      end
      else if (ph == "FFS") begin
        if (!fifo_full) nxt = "LAF";
      end
      else if (ph == "LAF") begin
        if (parity_done) nxt = "DA"; else if (low_pkt_valid) nxt = "LP"; else nxt = "LD";
      end
      else if (ph == "LP") nxt = "CPE";
      else if (ph == "CPE") begin
        if (fifo_full) nxt = "FFS"; else nxt = "DA";
      end
      else if (ph == "DROP") begin
        if (!pkt_valid) nxt = "DA";
      end
      m_drop = (nxt == "DROP" && ph != "DROP");
      if (nxt == "WTE" && ph != "WTE") m_wait = 0;
      ph = nxt;
    end
  end

  function automatic logic [10:0] model_out();
    logic wr, bz;
    wr = (ph == "LD") || (ph == "LP") || (ph == "LAF");
    bz = !((ph == "DA") || (ph == "LD") || (ph == "DROP"));
    return {(ph == "DA"), (ph == "LFD"), (ph == "LD"), (ph == "LAF"), (ph == "FFS"),
            (ph == "CPE"), wr, bz, m_drop, 2'(m_dest)};
  endfunction

  function automatic string model_letter();
    if (ph == "DA")  return "A";
    if (ph == "LFD") return "F";
    if (ph == "LD")  return "L";
    if (ph == "WTE") return "W";
    if (ph == "FFS") return "U";
    if (ph == "LAF") return "R";
    if (ph == "LP")  return "P";
    if (ph == "CPE") return "C";
    return "D";
  endfunction

  function automatic string dut_letter();
    if (detect_add)    return "A";
    if (lfd_state)     return "F";
    if (ld_state)      return "L";
    if (laf_state)     return "R";
    if (full_state)    return "U";
    if (rst_int_reg)   return "C";
    if (write_enb_reg) return "P";
    if (busy)          return "W";
    return "D";
  endfunction

  string dut_tr = "";
  string mdl_tr = "";
  int    wr_cnt = 0;
  int    drop_cnt = 0;

  always @(posedge clk) begin
    #1;
    chk($sformatf("outputs[%s]", ph),
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
         write_enb_reg, busy, drop_pkt, dest_sel}, model_out());
    dut_tr = {dut_tr, dut_letter()};
    mdl_tr = {mdl_tr, model_letter()};
    if (write_enb_reg) wr_cnt++;
    if (drop_pkt) drop_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    dut_tr = ""; mdl_tr = ""; wr_cnt = 0; drop_cnt = 0;
  endtask

  task automatic trace(input string name, input string exp);
    chk_str({name, "_dut"}, dut_tr, exp);
    chk_str({name, "_model"}, mdl_tr, exp);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_detect_add", 32'(detect_add), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_write_enb", 32'(write_enb_reg), 32'd0);
    chk("reset_dest_sel", 32'(dest_sel), 32'd0);

    // Normal packet to channel 2, four payload cycles.
    clear();
    pkt_valid = 1'b1; din = 2'd2; tick();
    din = 2'd0; repeat (4) tick();
    pkt_valid = 1'b0; repeat (3) tick();
    trace("normal", "FLLLLPCA");
    chk("normal_wr_cnt", 32'(wr_cnt), 32'd5);
    chk("normal_dest_sel", 32'(dest_sel), 32'd2);
    $display("txn normal: trace %s", dut_tr);

    // Wait for channel 1; channel 0 empty flag must be ignored.
    clear();
    fifo_empty = 3'b101; pkt_valid = 1'b1; din = 2'd1; tick();
    fifo_empty = 3'b100; tick();
    fifo_empty = 3'b101; tick();
    fifo_empty = 3'b100; tick();
    fifo_empty = 3'b111; tick();
    pkt_valid = 1'b0; repeat (4) tick();
    trace("wait", "WWWWFLPCA");
    $display("txn wait: trace %s", dut_tr);

    // Illegal address 3 is dropped.
    clear();
    pkt_valid = 1'b1; din = 2'd3; repeat (6) tick();
    pkt_valid = 1'b0; tick();
    trace("drop", "DDDDDDA");
    chk("drop_pulses", 32'(drop_cnt), 32'd1);
    chk("drop_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("drop_dest_sel", 32'(dest_sel), 32'd1);
    $display("txn drop: trace %s", dut_tr);

    // Full recovery ending through low_pkt_valid.
    clear();
    pkt_valid = 1'b1; din = 2'd0; tick(); tick();
    fifo_full = 1'b1; repeat (3) tick();
    fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0; tick(); tick();
    low_pkt_valid = 1'b0; tick(); tick();
    trace("full_low", "FLUUURPCA");
    $display("txn full_low: trace %s", dut_tr);

    // Full recovery ending through parity_done.
    clear();
    pkt_valid = 1'b1; din = 2'd0; tick(); tick();
    fifo_full = 1'b1; repeat (3) tick();
    fifo_full = 1'b0; parity_done = 1'b1; pkt_valid = 1'b0; tick(); tick();
    parity_done = 1'b0;
    trace("full_parity", "FLUUURA");
    $display("txn full_parity: trace %s", dut_tr);

    // Soft reset: only the selected channel's bit matters.
    clear();
    pkt_valid = 1'b1; din = 2'd0; tick(); tick();
    soft_rst = 3'b010; tick();
    soft_rst = 3'b001; tick();
    soft_rst = 3'b000; pkt_valid = 1'b0;
    trace("soft_rst", "FLLA");
    $display("txn soft_rst: trace %s", dut_tr);

    // Asynchronous reset mid-packet.
    pkt_valid = 1'b1; din = 2'd2; tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("async_rst_detect_add", 32'(detect_add), 32'd1);
    chk("async_rst_dest_sel", 32'(dest_sel), 32'd0);
    chk("async_rst_ld_state", 32'(ld_state), 32'd0);
    #1;
    rst = 1'b0; pkt_valid = 1'b0;
    tick();
    $display("txn async_rst: dest_sel %0d", dest_sel);

`ifdef WAIT_TIMEOUT_EN
    // Destination never drains: drop after exactly WT cycles of waiting.
    clear();
    fifo_empty = 3'b110; pkt_valid = 1'b1; din = 2'd0; tick();
    repeat (WT) tick();
    pkt_valid = 1'b0; tick();
    trace("timeout", "WWWWWWWWDA");
    chk("timeout_pulses", 32'(drop_cnt), 32'd1);
    $display("txn timeout: trace %s", dut_tr);

    // Destination drains in the last allowed cycle: empty wins.
    clear();
    fifo_empty = 3'b110; pkt_valid = 1'b1; din = 2'd0; tick();
    repeat (WT - 1) tick();
    fifo_empty = 3'b111; tick();
    pkt_valid = 1'b0; repeat (4) tick();
    trace("timeout_edge", "WWWWWWWWFLPCA");
    chk("timeout_edge_pulses", 32'(drop_cnt), 32'd0);
    $display("txn timeout_edge: trace %s", dut_tr);
`else
    // Without a timeout the wait holds until the soft reset releases it.
    clear();
    fifo_empty = 3'b110; pkt_valid = 1'b1; din = 2'd0; tick();
    repeat (11) tick();
    soft_rst = 3'b001; tick();
    soft_rst = 3'b000; pkt_valid = 1'b0; fifo_empty = 3'b111;
    trace("wait_hold", "WWWWWWWWWWWWA");
    chk("wait_hold_pulses", 32'(drop_cnt), 32'd0);
    $display("txn wait_hold: trace %s", dut_tr);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
